speed_meas_ctrl: RTL and testbench

- Sequencer for one phase-to-speed averaging/scaling unit, sitting between the Hilbert phase path and the speed consumer.
- Generates the decimated `sample` strobe and clears the averager on start.
- Discards the first results after start, while the averager pipeline settles.
- Captures each new speed result and presents it on a valid/ack handshake, with a sticky overrun flag.

---
 rtl/speed_meas_ctrl.sv | 167 ++++++++++++++++
 tb/tb_speed_meas_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speed_meas_ctrl.sv
// speed_meas_ctrl
// ---------------
// Sequencer for one phase-to-speed averaging/scaling unit. It clears the
// averager when measurement starts, generates the decimated `sample` strobe,
// throws away the first SETTLE averager results while the averager pipeline
// fills, and then captures every new result into a valid/ack output
// register. A sticky overrun flag records that a pending result was
// overwritten before it was acknowledged.
//
// Parameters
//   DIV     clock cycles per sample strobe (>= 2)
//   SETTLE  averager results discarded after each start (0 allowed)
//   SP_W    speed width (signed 6Q10)
//   CNT_W   delivered-result counter width
//
// Ports
//   clock        system clock
//   reset        asynchronous active-low reset
//   enable       1 = measure, 0 = stop
//   sample_out   one-cycle strobe to the averager `sample` input
//   avg_rst      active-high synchronous clear to the averager
//   avg_ready    averager ready level (rises once per result)
//   avg_speed    averager speed output (signed)
//   speed        captured speed, stable while speed_valid = 1
//   speed_valid  captured speed pending
//   speed_ack    consumer accepts speed (only while speed_valid = 1)
//   overrun      sticky: a result was overwritten before ack
//   clear_ovr    clears overrun (a simultaneous overrun wins)
//   busy         1 in every state except IDLE
//   result_cnt   results delivered since last start (wraps)

module speed_meas_ctrl #(
  parameter int DIV    = 100,
  parameter int SETTLE = 2,
  parameter int SP_W   = 16,
  parameter int CNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic                    sample_out,
  output logic                    avg_rst,
  input  logic                    avg_ready,
  input  logic signed [SP_W-1:0]  avg_speed,
  output logic signed [SP_W-1:0]  speed,
  output logic                    speed_valid,
  input  logic                    speed_ack,
  output logic                    overrun,
  input  logic                    clear_ovr,
  output logic                    busy,
  output logic [CNT_W-1:0]        result_cnt
);

  localparam int DV_W = $clog2(DIV);
  localparam int ST_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  localparam logic [DV_W-1:0] DIV_LAST    = DV_W'(DIV - 1);
  localparam logic [ST_W-1:0] SETTLE_INIT = ST_W'(SETTLE);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [DV_W-1:0]   div_cnt;
  logic [DV_W-1:0]   div_nx;
  logic [ST_W-1:0]   settle_cnt;
  logic              ready_q;
  logic              new_res;
  logic              capture;
  logic              running;
  logic              running_nx;

  // One pulse per averager result: avg_ready is a level that stays high
  // until the next strobe, so only its rising edge marks a new result.
  assign new_res = avg_ready & ~ready_q;
  assign capture = (state == ST_RUN) & new_res;
  assign running = (state == ST_SETTLE) || (state == ST_RUN);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (enable) state_nx = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (!enable)          state_nx = ST_IDLE;
        else if (SETTLE == 0) state_nx = ST_RUN;
        else                  state_nx = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable)                                   state_nx = ST_IDLE;
        else if (new_res && settle_cnt == ST_W'(1))    state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign running_nx = (state_nx == ST_SETTLE) || (state_nx == ST_RUN);

  // The divider only advances while already running and staying running, so
  // the first running cycle after CLEAR starts at 0 and SETTLE->RUN keeps
  // the strobe phase without a gap.
  always_comb begin
    div_nx = '0;
    if (running && running_nx) begin
      if (div_cnt == DIV_LAST) div_nx = '0;
      else                     div_nx = div_cnt + DV_W'(1);
    end
  end

  // Outputs are registered from the next-state/next-divider values so that
  // sample_out, avg_rst and busy line up with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      settle_cnt  <= '0;
      ready_q     <= 1'b0;
      sample_out  <= 1'b0;
      avg_rst     <= 1'b1;
      busy        <= 1'b0;
      speed       <= '0;
      speed_valid <= 1'b0;
      overrun     <= 1'b0;
      result_cnt  <= '0;
    end else begin
      state      <= state_nx;
      div_cnt    <= div_nx;
      ready_q    <= avg_ready;
      sample_out <= running_nx && (div_nx == DIV_LAST);
      avg_rst    <= !running_nx;
      busy       <= (state_nx != ST_IDLE);

      if (state == ST_CLEAR)
        settle_cnt <= SETTLE_INIT;
      else if ((state == ST_SETTLE) && new_res)
        settle_cnt <= settle_cnt - ST_W'(1);

      if (state == ST_CLEAR)
        result_cnt <= '0;
      else if (capture)
        result_cnt <= result_cnt + CNT_W'(1);

      // A capture always wins over an ack: the new value stays pending.
      if (capture) begin
        speed       <= avg_speed;
        speed_valid <= 1'b1;
      end else if (speed_ack && speed_valid) begin
        speed_valid <= 1'b0;
      end

      if (capture && speed_valid && !speed_ack)
        overrun <= 1'b1;
      else if (clear_ovr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_speed_meas_ctrl.sv
// tb_speed_meas_ctrl
// Bench for speed_meas_ctrl. The main instance (DIV=4, SETTLE=2) is driven
// by a small behavioural averager that produces one result per 5 strobes;
// results expected to be captured are queued when produced and popped when
// the controller presents them. A second instance (DIV=2, SETTLE=0) is
// driven directly to cover immediate RUN and ack-during-capture.

module tb_speed_meas_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // main instance
  logic               enable = 1'b0;
  logic               avg_ready = 1'b0;
  logic signed [15:0] avg_speed = '0;
  logic               speed_ack = 1'b0;
  logic               clear_ovr = 1'b0;
  logic               sample_out, avg_rst, speed_valid, overrun, busy;
  logic signed [15:0] speed;
  logic [15:0]        result_cnt;

  // second instance
  logic               en_b = 1'b0;
  logic               rdy_b = 1'b0;
  logic signed [15:0] spd_in_b = '0;
  logic               ack_b = 1'b0;
  logic               clr_b = 1'b0;
  logic               sample_out_b, avg_rst_b, valid_b, ovr_b, busy_b;
  logic signed [15:0] speed_b;
  logic [15:0]        cnt_b;

  int n_chk  = 0;
  int n_pass = 0;

  // averager model / scoreboard state
  int                 cyc = 0;
  int                 nstb = 0;
  int                 res_k = 0;
  int                 settle_left = 0;
  int                 strobe_n = 0;
  int                 cap_seen = 0;
  int                 first_cap_strobe = -1;
  int                 last_cap_cyc = 0;
  int                 exp_cnt = 0;
  int                 ack_mode = 0;
  int                 n;
  bit                 cap_pending = 1'b0;
  bit                 clr_on_res = 1'b0;
  bit                 exp_valid = 1'b0;
  bit                 exp_ovr = 1'b0;
  logic signed [15:0] sb_q[$];
  logic signed [15:0] sb_b[$];
  logic signed [15:0] exp_b;

  always #5 clock = ~clock;

  speed_meas_ctrl #(.DIV(4), .SETTLE(2), .SP_W(16), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .sample_out(sample_out), .avg_rst(avg_rst),
    .avg_ready(avg_ready), .avg_speed(avg_speed),
    .speed(speed), .speed_valid(speed_valid), .speed_ack(speed_ack),
    .overrun(overrun), .clear_ovr(clear_ovr), .busy(busy),
    .result_cnt(result_cnt)
  );

  speed_meas_ctrl #(.DIV(2), .SETTLE(0), .SP_W(16), .CNT_W(16)) dut0 (
    .clock(clock), .reset(reset), .enable(en_b),
    .sample_out(sample_out_b), .avg_rst(avg_rst_b),
    .avg_ready(rdy_b), .avg_speed(spd_in_b),
    .speed(speed_b), .speed_valid(valid_b), .speed_ack(ack_b),
    .overrun(ovr_b), .clear_ovr(clr_b), .busy(busy_b),
    .result_cnt(cnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic signed [15:0] gen(input int k);
    if (k % 2 != 0) return 16'(-(500 + 7 * k));
    else            return 16'(1024 + 3 * k);
  endfunction

  // One clock cycle: advance, check the scoreboard, then update the
  // averager model and the consumer for the next cycle.
  task automatic step();
    logic s_pre, r_pre, ack_pre, clr_pre, cap;
    logic signed [15:0] exp_spd;
    s_pre   = sample_out;
    r_pre   = avg_rst;
    ack_pre = speed_ack;
    clr_pre = clear_ovr;
    cap     = cap_pending;
    @(posedge clock);
    #1;
    cyc++;
    if (cap) begin
      cap_pending = 1'b0;
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_spd = sb_q.pop_front();
        if (exp_valid && !ack_pre) exp_ovr = 1'b1;
        else if (clr_pre)          exp_ovr = 1'b0;
        exp_valid = 1'b1;
        exp_cnt++;
        cap_seen++;
        check_eq("cap_speed", speed, exp_spd);
        check_eq("cap_cnt", result_cnt, exp_cnt & 32'hFFFF);
        if (cap_seen == 1) first_cap_strobe = strobe_n;
        else check_eq("cap_period", cyc - last_cap_cyc, 20);
        last_cap_cyc = cyc;
      end
    end else begin
      if (ack_pre && exp_valid) exp_valid = 1'b0;
      if (clr_pre) exp_ovr = 1'b0;
    end
    check_eq("valid", speed_valid, exp_valid);
    check_eq("ovr", overrun, exp_ovr);
    if (sample_out) strobe_n++;

    if (r_pre) begin
      nstb = 0;
      avg_ready = 1'b0;
    end else if (s_pre) begin
      nstb++;
      if (nstb == 5) begin
        nstb = 0;
        avg_ready = 1'b1;
        avg_speed = gen(res_k);
        res_k++;
        if (settle_left > 0) settle_left--;
        else begin
          sb_q.push_back(avg_speed);
          cap_pending = 1'b1;
        end
      end else begin
        avg_ready = 1'b0;
      end
    end

    speed_ack = (ack_mode == 0) && speed_valid;
    clear_ovr = 1'b0;
    if (clr_on_res && cap_pending) begin
      clear_ovr  = 1'b1;
      clr_on_res = 1'b0;
    end
  endtask

  task automatic start();
    enable      = 1'b1;
    settle_left = 2;
    strobe_n    = 0;
    exp_cnt     = 0;
    cap_seen    = 0;
    step();
    check_eq("clear_busy", busy, 1);
    check_eq("clear_avg_rst", avg_rst, 1);
    check_eq("clear_sample", sample_out, 0);
    step();
    check_eq("settle_avg_rst", avg_rst, 0);
    check_eq("restart_cnt", result_cnt, 0);
  endtask

  task automatic wait_strobe(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!sample_out && cnt < 64);
  endtask

  task automatic wait_caps(input int k, input int budget);
    int target;
    int i;
    target = cap_seen + k;
    i = 0;
    while (cap_seen < target && i < budget) begin
      step();
      i++;
    end
    if (cap_seen < target) check_eq("cap_timeout", cap_seen, target);
  endtask

  task automatic stop_and_check(input string tag);
    enable = 1'b0;
    step();
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_avg_rst"}, avg_rst, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq({tag, "_no_strobe"}, sample_out, 0);
    end
  endtask

  initial begin
    // reset values
    step();
    step();
    check_eq("rst_sample", sample_out, 0);
    check_eq("rst_avg_rst", avg_rst, 1);
    check_eq("rst_speed", speed, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", result_cnt, 0);
    reset = 1'b1;
    step();

    // start: CLEAR, first strobe DIV cycles on, then period DIV
    ack_mode = 0;
    start();
    wait_strobe(n);
    check_eq("first_strobe", n, 3);
    wait_strobe(n);
    check_eq("strobe_period", n, 4);
    wait_strobe(n);
    check_eq("strobe_period2", n, 4);

    // settle discards two results; acked results 1..3
    wait_caps(1, 200);
    check_eq("first_cap_strobe", first_cap_strobe, 15);
    wait_caps(2, 100);

    // no acks: overwrite sets overrun; set beats a simultaneous clear
    ack_mode = 1;
    wait_caps(2, 100);
    check_eq("ovr_set", overrun, 1);
    clr_on_res = 1'b1;
    wait_caps(1, 100);
    check_eq("ovr_set_wins", overrun, 1);
    step();
    clear_ovr = 1'b1;
    step();
    check_eq("ovr_cleared", overrun, 0);

    // stop with a pending result: it stays pending
    stop_and_check("stop_run");
    check_eq("pending_kept", speed_valid, 1);

    // restart, then stop mid-SETTLE after one discard
    ack_mode = 0;
    start();
    for (int i = 0; i < 200 && settle_left != 1; i++) step();
    check_eq("settle_reached", settle_left, 1);
    step();
    step();
    stop_and_check("stop_settle");

    // re-enable: a full settle of two results again
    start();
    wait_caps(1, 200);
    check_eq("resettle_cap_strobe", first_cap_strobe, 15);
    check_eq("resettle_cnt", result_cnt, 1);

    // asynchronous reset while running
    step();
    #3;
    reset  = 1'b0;
    enable = 1'b0;
    #1;
    check_eq("arst_sample", sample_out, 0);
    check_eq("arst_avg_rst", avg_rst, 1);
    check_eq("arst_speed", speed, 0);
    check_eq("arst_valid", speed_valid, 0);
    check_eq("arst_ovr", overrun, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_cnt", result_cnt, 0);
    exp_valid   = 1'b0;
    exp_ovr     = 1'b0;
    cap_pending = 1'b0;
    sb_q.delete();
    avg_ready   = 1'b0;
    step();
    reset = 1'b1;
    step();

    // SETTLE=0, DIV=2 instance
    en_b = 1'b1;
    step();
    check_eq("b_clear_busy", busy_b, 1);
    check_eq("b_clear_avg_rst", avg_rst_b, 1);
    step();
    check_eq("b_run_avg_rst", avg_rst_b, 0);
    check_eq("b_strobe0", sample_out_b, 0);
    step();
    check_eq("b_strobe1", sample_out_b, 1);
    step();
    check_eq("b_strobe2", sample_out_b, 0);
    step();
    check_eq("b_strobe3", sample_out_b, 1);

    rdy_b = 1'b1;
    spd_in_b = -16'sd300;
    sb_b.push_back(spd_in_b);
    step();
    exp_b = sb_b.pop_front();
    check_eq("b_cap1_valid", valid_b, 1);
    check_eq("b_cap1_speed", speed_b, exp_b);
    check_eq("b_cap1_cnt", cnt_b, 1);
    rdy_b = 1'b0;
    step();
    rdy_b = 1'b1;
    ack_b = 1'b1;
    spd_in_b = 16'sd777;
    sb_b.push_back(spd_in_b);
    step();
    exp_b = sb_b.pop_front();
    check_eq("b_cap2_valid", valid_b, 1);
    check_eq("b_cap2_speed", speed_b, exp_b);
    check_eq("b_cap2_ovr", ovr_b, 0);
    check_eq("b_cap2_cnt", cnt_b, 2);
    rdy_b = 1'b0;
    ack_b = 1'b0;
    step();
    check_eq("b_hold_valid", valid_b, 1);
    ack_b = 1'b1;
    step();
    ack_b = 1'b0;
    check_eq("b_ack_valid", valid_b, 0);
    check_eq("b_ack_ovr", ovr_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
